// File: rtl/pcpi_cmd_issuer.sv
// rtl/pcpi_cmd_issuer.sv - PCPI initiator issuing buffered host commands as custom-0 instructions
// Optional feature macro: PCPI_ISSUER_TIMEOUT_EN (abort an ISSUE that outlasts TIMEOUT_CYCLES)
module pcpi_cmd_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int START_SETTLE   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_funct3,
    input  logic [4:0]                    cmd_addr,
    input  logic [15:0]                   cmd_value,
    output logic                          pcpi_valid,
    output logic [31:0]                   pcpi_insn,
    input  logic                          pcpi_wr,
    input  logic [31:0]                   pcpi_rd,
    input  logic                          pcpi_wait,
    input  logic                          pcpi_ready,
    output logic                          rsp_valid,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_wr,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(START_SETTLE + TIMEOUT_CYCLES + 2);
    localparam logic [LVL_W-1:0] FULL_LVL     = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] SETTLE_CNT   = CNT_W'(START_SETTLE);
    localparam logic [6:0]       OPCODE       = 7'b0001011;
    localparam logic [2:0]       START_FUNCT3 = 3'b111;
`ifdef PCPI_ISSUER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t           state, state_next;
    logic [23:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] issue_cnt;
    logic             full, empty, push, pop, complete, allowed;
`ifdef PCPI_ISSUER_TIMEOUT_EN
    logic             abort;
`endif
    logic             unused_wait;

    assign unused_wait = pcpi_wait;
    assign full      = (fifo_level == FULL_LVL);
    assign empty     = (fifo_level == '0);
    assign cmd_ready = resetn && !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = !empty || (state != IDLE);
    // Start commands need the coprocessor to settle before its ready is trusted
    assign allowed   = (pcpi_insn[14:12] != START_FUNCT3) || (issue_cnt >= SETTLE_CNT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        complete   = 1'b0;
`ifdef PCPI_ISSUER_TIMEOUT_EN
        abort      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (pcpi_ready && allowed) begin
                    complete   = 1'b1;
                    state_next = GAP;
                end
`ifdef PCPI_ISSUER_TIMEOUT_EN
                else if (issue_cnt == TIMEOUT_CNT) begin
                    abort      = 1'b1;
                    state_next = GAP;
                end
`endif
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_value, cmd_funct3, cmd_addr};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            issue_cnt  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_wr     <= 1'b0;
`ifdef PCPI_ISSUER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            if (pop) begin
                pcpi_insn  <= {1'b0, mem[rd_ptr], OPCODE};
                pcpi_valid <= 1'b1;
                issue_cnt  <= '0;
            end else if (state == ISSUE && issue_cnt != '1) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (complete) begin
                pcpi_valid <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_data   <= pcpi_wr ? pcpi_rd : 32'd0;
                rsp_wr     <= pcpi_wr;
`ifdef PCPI_ISSUER_TIMEOUT_EN
                rsp_timeout <= 1'b0;
`endif
            end
`ifdef PCPI_ISSUER_TIMEOUT_EN
            if (abort) begin
                pcpi_valid  <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_data    <= '0;
                rsp_wr      <= 1'b0;
                rsp_timeout <= 1'b1;
            end
`endif
        end
    end

`ifndef PCPI_ISSUER_TIMEOUT_EN
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_cmd_issuer.sv
// tb/tb_pcpi_cmd_issuer.sv - directed bench for pcpi_cmd_issuer with a queue-based reference model
module tb_pcpi_cmd_issuer;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
    localparam int TOUT   = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_funct3 = '0;
    logic [4:0]  cmd_addr = '0;
    logic [15:0] cmd_value = '0;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_wait = 1'b0;
    logic        pcpi_ready = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_wr;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  fifo_level;

    int vectors = 0;
    int errors  = 0;
    int rsp_count = 0;

    pcpi_cmd_issuer #(
        .FIFO_DEPTH(DEPTH), .START_SETTLE(SETTLE), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct3(cmd_funct3), .cmd_addr(cmd_addr), .cmd_value(cmd_value),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_wr(rsp_wr), .rsp_timeout(rsp_timeout),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [2:0] f, input logic [4:0] a, input logic [15:0] v);
        return {1'b0, v, f, a, 7'b0001011};
    endfunction

    // Reference model: queued commands, the one in flight, and a one-cycle cooldown after each response
    logic [31:0] mq[$];
    logic [31:0] m_cur = '0;
    logic        m_fly = 1'b0;
    logic        m_cool = 1'b0;
    int          m_k = 0;
    logic        m_rv = 1'b0;
    logic        m_rwr = 1'b0;
    logic        m_rto = 1'b0;
    logic [31:0] m_rdata = '0;

    always @(negedge clk) begin
        logic push_ok;
        logic allow;
        if (!resetn) begin
            mq.delete();
            m_cur = '0; m_fly = 1'b0; m_cool = 1'b0; m_k = 0;
            m_rv = 1'b0; m_rwr = 1'b0; m_rto = 1'b0; m_rdata = '0;
        end
        chk("pcpi_valid", {31'd0, pcpi_valid}, {31'd0, m_fly});
        chk("pcpi_insn", pcpi_insn, m_cur);
        chk("fifo_level", {29'd0, fifo_level}, 32'(mq.size()));
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, resetn && (mq.size() < DEPTH)});
        chk("busy", {31'd0, busy}, {31'd0, (mq.size() != 0) || m_fly || m_cool});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
        chk("rsp_data", rsp_data, m_rdata);
        chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, m_rwr});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, m_rto});
        if (resetn) begin
            if (rsp_valid) rsp_count++;
            push_ok = cmd_valid && (mq.size() < DEPTH);
            m_rv = 1'b0;
            if (m_fly) begin
                m_k++;
                allow = (m_cur[14:12] != 3'b111) || (m_k > SETTLE);
                if (pcpi_ready && allow) begin
                    m_rv = 1'b1; m_rdata = pcpi_wr ? pcpi_rd : 32'd0; m_rwr = pcpi_wr; m_rto = 1'b0;
                    m_fly = 1'b0; m_cool = 1'b1;
                end
`ifdef PCPI_ISSUER_TIMEOUT_EN
                else if (m_k == TOUT) begin
                    m_rv = 1'b1; m_rdata = '0; m_rwr = 1'b0; m_rto = 1'b1;
                    m_fly = 1'b0; m_cool = 1'b1;
                end
`endif
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (mq.size() != 0) begin
                m_cur = mq.pop_front();
                m_fly = 1'b1;
                m_k = 0;
            end
            if (push_ok) mq.push_back(pack(cmd_funct3, cmd_addr, cmd_value));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] f, input logic [4:0] a, input logic [15:0] v);
        logic acc;
        acc = 1'b0;
        cmd_funct3 = f; cmd_addr = a; cmd_value = v; cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!acc) chk("push_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !pcpi_valid; i++) tick();
        chk("wait_valid", {31'd0, pcpi_valid}, 32'd1);
    endtask

    initial begin
        int pulses, done_at, hi, rsp_at, base;
        logic to_flag;
        logic [31:0] to_data;
        logic sent, acc;

        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Plain command, ready already high: one-cycle issue
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd0;
        push_cmd(3'd0, 5'd0, 16'd5);
        wait_valid();
        chk("insn_t1", pcpi_insn, 32'h0002800B);
        tick();
        chk("t1_valid_drop", {31'd0, pcpi_valid}, 32'd0);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_data", rsp_data, 32'd0);
        chk("t1_rsp_wr", {31'd0, rsp_wr}, 32'd1);
        repeat (2) tick();

        // Negative immediate and nonzero address, then a no-write response
        pcpi_rd = 32'h1234_5678;
        push_cmd(3'd0, 5'd27, 16'hFFBA);
        wait_valid();
        chk("insn_t2", pcpi_insn, 32'h7FDD0D8B);
        tick();
        chk("t2_rsp_data", rsp_data, 32'h1234_5678);
        pcpi_wr = 1'b0; pcpi_rd = 32'hDEAD_BEEF;
        push_cmd(3'd3, 5'd4, 16'd100);
        wait_valid();
        chk("insn_t2b", pcpi_insn, 32'h0032320B);
        tick();
        chk("t2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2b_rsp_data", rsp_data, 32'd0);
        chk("t2b_rsp_wr", {31'd0, rsp_wr}, 32'd0);

        // Start command ignores the early ready
        pcpi_wr = 1'b1; pcpi_rd = 32'h0000_00A5;
        push_cmd(3'd7, 5'd0, 16'd0);
        wait_valid();
        chk("insn_t3", pcpi_insn, 32'h0000700B);
        pulses = 0; done_at = 0;
        for (int c = 1; c <= 12; c++) begin
            pcpi_ready = (c == 1 || c == 10);
            tick();
            if (rsp_valid) begin pulses++; done_at = c; end
        end
        chk("t3_pulses", 32'(pulses), 32'd1);
        chk("t3_done_cycle", 32'(done_at), 32'd10);

        // Back-to-back pushes against a stalled coprocessor until the FIFO fills
        pcpi_ready = 1'b0;
        base = rsp_count;
        for (int i = 0; i < 5; i++)
            push_cmd((i == 4) ? 3'd7 : 3'(i), 5'(i + 10), 16'(i * 1000 - 2000));
        chk("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("t4_full_level", {29'd0, fifo_level}, 32'd4);
        cmd_funct3 = 3'd5; cmd_addr = 5'd31; cmd_value = 16'h8000; cmd_valid = 1'b1;
        pcpi_ready = 1'b1; sent = 1'b0;
        for (int i = 0; i < 200 && !(sent && !busy); i++) begin
            acc = cmd_valid && cmd_ready;
            pcpi_rd = pcpi_rd + 32'h0101_0101;
            tick();
            if (acc) begin sent = 1'b1; cmd_valid = 1'b0; end
        end
        cmd_valid = 1'b0;
        chk("t4_sixth_sent", {31'd0, sent}, 32'd1);
        chk("t4_drained", {31'd0, busy}, 32'd0);
        chk("t4_rsp_count", 32'(rsp_count - base), 32'd6);

        // Coprocessor that never answers
        pcpi_ready = 1'b0; pcpi_wait = 1'b1;
        push_cmd(3'd1, 5'd2, 16'd3);
        wait_valid();
        hi = 1; rsp_at = 0; to_flag = 1'b0; to_data = 32'hFFFF_FFFF;
        for (int j = 1; j <= 210; j++) begin
            tick();
            if (rsp_valid && rsp_at == 0) begin rsp_at = j; to_flag = rsp_timeout; to_data = rsp_data; end
            if (pcpi_valid) hi++;
        end
`ifdef PCPI_ISSUER_TIMEOUT_EN
        chk("t5_valid_cycles", 32'(hi), 32'd64);
        chk("t5_rsp_at", 32'(rsp_at), 32'd64);
        chk("t5_timeout_flag", {31'd0, to_flag}, 32'd1);
        chk("t5_timeout_data", to_data, 32'd0);
`else
        chk("t5_valid_cycles", 32'(hi), 32'd211);
        chk("t5_no_rsp", 32'(rsp_at), 32'd0);
`endif
        pcpi_wait = 1'b0;

        // Reset while a command is in flight and another is queued
        if (!pcpi_valid) begin
            push_cmd(3'd4, 5'd5, 16'd6);
            wait_valid();
        end
        push_cmd(3'd2, 5'd1, 16'd1);
        chk("t6_level_before", {29'd0, fifo_level}, 32'd1);
        base = rsp_count;
        resetn = 1'b0;
        #1;
        chk("t6_valid_rst", {31'd0, pcpi_valid}, 32'd0);
        chk("t6_busy_rst", {31'd0, busy}, 32'd0);
        chk("t6_level_rst", {29'd0, fifo_level}, 32'd0);
        chk("t6_ready_rst", {31'd0, cmd_ready}, 32'd0);
        tick();
        resetn = 1'b1;
        pcpi_ready = 1'b1;
        repeat (10) tick();
        chk("t6_no_rsp", 32'(rsp_count - base), 32'd0);
        chk("t6_idle", {31'd0, busy}, 32'd0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
